// File: rtl/divider_stream_adapter.sv
// rtl/divider_stream_adapter.sv - valid/ready front-end for an iterative start/done divider
// Launches one division at a time, resolves zero divisors locally, and buffers results in a 2-entry FIFO.
module divider_stream_adapter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_dividend,
    input  logic [WIDTH-1:0] in_divisor,
    output logic             div_start,
    output logic [WIDTH-1:0] div_dividend,
    output logic [WIDTH-1:0] div_divisor,
    input  logic             div_done,
    input  logic [WIDTH-1:0] div_quotient,
    input  logic [WIDTH-1:0] div_remainder,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_quotient,
    output logic [WIDTH-1:0] out_remainder,
    output logic             out_div_by_zero
);

    typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

    localparam int EW = 2 * WIDTH + 1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] dividend_q, dividend_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic [EW-1:0]    mem_q [2];
    logic [EW-1:0]    mem_d [2];
    logic             rd_ptr_q, rd_ptr_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             accept;
    logic             push;
    logic             pop;
    logic [EW-1:0]    push_data;

    always_comb begin
        state_d    = state_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        push       = 1'b0;
        push_data  = '0;
        div_start  = 1'b0;
        in_ready   = (state_q == IDLE) && (count_q < 2'd2) && !rst;
        accept     = in_valid && in_ready;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (in_divisor == '0) begin
                        push      = 1'b1;
                        push_data = {{WIDTH{1'b1}}, in_dividend, 1'b1};
                    end else begin
                        dividend_d = in_dividend;
                        divisor_d  = in_divisor;
                        state_d    = START;
                    end
                end
            end
            START: begin
                // div_done may still be high from the previous op, so it is not looked at here
                div_start = !rst;
                state_d   = WAIT;
            end
            WAIT: begin
                if (div_done) begin
                    push      = 1'b1;
                    push_data = {div_quotient, div_remainder, 1'b0};
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // a single op in flight means a push never finds the FIFO full
        pop      = (count_q != 2'd0) && out_ready;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            dividend_q <= '0;
            divisor_q  <= '0;
            mem_q[0]   <= '0;
            mem_q[1]   <= '0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
        end else begin
            state_q    <= state_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            mem_q      <= mem_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    assign div_dividend = dividend_q;
    assign div_divisor  = divisor_q;
    assign out_valid    = (count_q != 2'd0);
    assign {out_quotient, out_remainder, out_div_by_zero} = mem_q[rd_ptr_q];

endmodule
